// File: rtl/dcache_store_wbuf_if.sv
// Store-in, drain-out, load-check and status signals of the dcache write-through store buffer.
// The slave modport is the buffer; the master modport is the LSU/memory side driving it.
interface dcache_store_wbuf_if #(
    parameter int XLEN      = 32,
    parameter int TID_WIDTH = 2
);
    logic                 st_valid_i;
    logic                 st_ready_o;
    logic [XLEN-1:0]      st_paddr_i;
    logic [XLEN-1:0]      st_data_i;
    logic [XLEN/8-1:0]    st_be_i;
    logic                 st_nc_i;

    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic [XLEN-1:0]      mem_paddr_o;
    logic [XLEN-1:0]      mem_data_o;
    logic [XLEN/8-1:0]    mem_be_o;
    logic [TID_WIDTH-1:0] mem_tid_o;
    logic                 mem_ack_i;
    logic [TID_WIDTH-1:0] mem_ack_tid_i;

    logic [XLEN-1:0]      ld_paddr_i;
    logic                 ld_hit_o;
    logic                 empty_o;
    logic                 full_o;

    modport slave (
        input  st_valid_i, st_paddr_i, st_data_i, st_be_i, st_nc_i,
        input  mem_gnt_i, mem_ack_i, mem_ack_tid_i, ld_paddr_i,
        output st_ready_o, mem_req_o, mem_paddr_o, mem_data_o, mem_be_o, mem_tid_o,
        output ld_hit_o, empty_o, full_o
    );

    modport master (
        output st_valid_i, st_paddr_i, st_data_i, st_be_i, st_nc_i,
        output mem_gnt_i, mem_ack_i, mem_ack_tid_i, ld_paddr_i,
        input  st_ready_o, mem_req_o, mem_paddr_o, mem_data_o, mem_be_o, mem_tid_o,
        input  ld_hit_o, empty_o, full_o
    );
endinterface

// File: rtl/dcache_store_wbuf.sv
// Write-through store buffer: merges same-word cacheable stores, drains in order over req/gnt,
// retires on in-order tagged acks, and flags loads that collide with a buffered store.
module dcache_store_wbuf #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int TID_WIDTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_store_wbuf_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int BW       = XLEN / 8;
    localparam int WA       = XLEN - 2;
    localparam int MAX_INFL = (DEPTH < (1 << TID_WIDTH)) ? DEPTH : (1 << TID_WIDTH);
    localparam logic [AW:0] DEPTH_P    = DEPTH[AW:0];
    localparam logic [AW:0] MAX_INFL_P = MAX_INFL[AW:0];

    typedef struct packed {
        logic [WA-1:0]   waddr;
        logic [XLEN-1:0] data;
        logic [BW-1:0]   be;
        logic            nc;
    } entry_t;

    entry_t               entries [DEPTH];
    logic [AW:0]          wr_ptr_q, iss_ptr_q, rd_ptr_q;
    logic [TID_WIDTH-1:0] iss_cnt_q, ret_cnt_q;

    logic [AW:0]     occupancy, unissued, inflight;
    logic [AW-1:0]   wr_idx, iss_idx, rd_idx, young_idx;
    logic [WA-1:0]   st_waddr, ld_waddr;
    logic            mem_req, issue_go, merge_ok, accept, do_merge, do_alloc, ack_ok;
    logic [XLEN-1:0] merge_data;
    logic            ld_hit;
    logic            unused_addr_bits;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign unissued  = wr_ptr_q - iss_ptr_q;
    assign inflight  = iss_ptr_q - rd_ptr_q;
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign iss_idx   = iss_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign young_idx = wr_idx - AW'(1);
    assign st_waddr  = bus.st_paddr_i[XLEN-1:2];
    assign ld_waddr  = bus.ld_paddr_i[XLEN-1:2];
    assign unused_addr_bits = ^{bus.st_paddr_i[1:0], bus.ld_paddr_i[1:0]};

    // A non-cacheable entry only leaves once everything older has been acknowledged.
    assign mem_req  = (unissued != '0) && (inflight < MAX_INFL_P)
                    && (!entries[iss_idx].nc || inflight == '0);
    assign issue_go = mem_req && bus.mem_gnt_i;

    // The youngest entry is the issuing one only when exactly one entry is unissued.
    assign merge_ok = (unissued != '0)
                    && !(issue_go && iss_idx == young_idx)
                    && (entries[young_idx].waddr == st_waddr)
                    && !entries[young_idx].nc && !bus.st_nc_i;

    assign bus.full_o     = (occupancy == DEPTH_P);
    assign bus.empty_o    = (occupancy == '0);
    assign bus.st_ready_o = !bus.full_o || merge_ok;

    assign accept   = bus.st_valid_i && bus.st_ready_o;
    assign do_merge = accept && merge_ok;
    assign do_alloc = accept && !merge_ok;
    assign ack_ok   = bus.mem_ack_i && (inflight != '0) && (bus.mem_ack_tid_i == ret_cnt_q);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merge_data = entries[young_idx].data;
        for (int b = 0; b < BW; b++) begin
            if (bus.st_be_i[b]) merge_data[8*b +: 8] = bus.st_data_i[8*b +: 8];
        end
    end

    // NOTE: the entry array has no reset; occupancy comes from the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_merge) begin
            entries[young_idx].data <= merge_data;
            entries[young_idx].be   <= entries[young_idx].be | bus.st_be_i;
        end else if (do_alloc) begin
            entries[wr_idx] <= '{waddr: st_waddr, data: bus.st_data_i,
                                 be: bus.st_be_i, nc: bus.st_nc_i};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            iss_ptr_q <= '0;
            rd_ptr_q  <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (do_alloc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue_go) begin
                iss_ptr_q <= iss_ptr_q + 1'b1;
                iss_cnt_q <= iss_cnt_q + 1'b1;
            end
            if (ack_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off = AW'(i) - rd_idx;
            if (({1'b0, off} < occupancy) && (entries[i].waddr == ld_waddr)) ld_hit = 1'b1;
        end
    end

    assign bus.ld_hit_o    = ld_hit;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_paddr_o = {entries[iss_idx].waddr, 2'b00};
    assign bus.mem_data_o  = entries[iss_idx].data;
    assign bus.mem_be_o    = entries[iss_idx].be;
    assign bus.mem_tid_o   = iss_cnt_q;
endmodule
